lsu_align: RTL

Load/store unit sitting directly downstream of the ALU in the RV32I datapath. It takes the byte address computed by the ALU for a load or store, plus the funct3 size/sign code and the store data, and runs one data-memory transaction over a request/grant + response handshake. It generates byte enables and replicates store data across lanes. For loads it extracts and sign- or zero-extends the addressed byte, half or word, then returns the result with a one-cycle done pulse.

---
 rtl/lsu_align.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - RV32I load/store aligner: byte enables, lane replication, load extraction.
// Optional LSU_MISALIGN_TRAP_EN rejects misaligned or illegal-funct3 accesses with o_fault.
module lsu_align #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    input  logic [2:0]        i_funct3,
    output logic              o_busy,
    output logic              o_done,
    output logic [31:0]       o_rdata,
    output logic              o_fault,
    output logic              o_mem_req,
    input  logic              i_mem_gnt,
    output logic [ADDR_W-3:0] o_mem_addr,
    output logic              o_mem_we,
    output logic [3:0]        o_mem_be,
    output logic [31:0]       o_mem_wdata,
    input  logic              i_mem_rvalid,
    input  logic [31:0]       i_mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t            state, next_state;
    logic              we_q;
    logic [1:0]        lo_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-3:0] addr_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;

    logic [1:0]        size_c;    // 0 byte, 1 half, 2 word
    logic [3:0]        be_c;
    logic [31:0]       wdata_c;
    logic              reject_c;
    logic              accept;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [31:0]       load_ext;

    assign accept = (state == IDLE) && i_start;

    // Anything that is not a recognised B/H size is handled as a word access.
    always_comb begin
        size_c = 2'd2;
        case (i_funct3)
            3'b000:  size_c = 2'd0;
            3'b001:  size_c = 2'd1;
            3'b100:  size_c = i_we ? 2'd2 : 2'd0;
            3'b101:  size_c = i_we ? 2'd2 : 2'd1;
            default: size_c = 2'd2;
        endcase
    end

    always_comb begin
        be_c    = 4'b1111;
        wdata_c = i_wdata;
        case (size_c)
            2'd0: begin
                be_c    = 4'b0001 << i_addr[1:0];
                wdata_c = {4{i_wdata[7:0]}};
            end
            2'd1: begin
                be_c    = 4'b0011 << {i_addr[1], 1'b0};
                wdata_c = {2{i_wdata[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = i_wdata;
            end
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic fault_q;
    logic illegal_c;
    logic misalign_c;

    always_comb begin
        illegal_c  = (i_funct3 == 3'b011) || (i_funct3 == 3'b110) || (i_funct3 == 3'b111)
                   || (i_we && i_funct3[2]);
        misalign_c = ((size_c == 2'd1) && i_addr[0]) || ((size_c == 2'd2) && (i_addr[1:0] != 2'b00));
        reject_c   = illegal_c || misalign_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else if (accept) begin
            fault_q <= reject_c;
        end
    end

    assign o_fault = fault_q && (state == DONE);
`else
    assign reject_c = 1'b0;
    assign o_fault  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (i_start) next_state = reject_c ? DONE : REQ;
            REQ:  if (i_mem_gnt) next_state = we_q ? DONE : WAIT;
            WAIT: if (i_mem_rvalid) next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Memory-side request fields are computed once at accept and held until grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            lo_q    <= 2'b00;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            be_q    <= 4'b0000;
            wdata_q <= 32'h0;
        end else if (accept) begin
            we_q    <= i_we;
            lo_q    <= i_addr[1:0];
            f3_q    <= i_funct3;
            addr_q  <= i_addr[ADDR_W-1:2];
            be_q    <= be_c;
            wdata_q <= wdata_c;
        end
    end

    always_comb begin
        byte_sel = i_mem_rdata[{lo_q, 3'b000} +: 8];
        half_sel = lo_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
        case (f3_q)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_ext = {24'h0, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_ext = {16'h0, half_sel};
            default: load_ext = i_mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= 32'h0;
        end else if ((state == WAIT) && i_mem_rvalid) begin
            rdata_q <= load_ext;
        end
    end

    assign o_busy      = (state != IDLE);
    assign o_done      = (state == DONE);
    assign o_mem_req   = (state == REQ);
    assign o_rdata     = rdata_q;
    assign o_mem_addr  = addr_q;
    assign o_mem_we    = we_q;
    assign o_mem_be    = be_q;
    assign o_mem_wdata = wdata_q;

endmodule
